// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 16x oversampling UART receiver.
//   OS_RATE   : enable_16 ticks per bit period
//   OS_MID    : tick index at which the start bit is re-checked (half a bit)
//   DATA_BITS : payload width of one frame
//   rx_state_e: receiver FSM states (PARITY only exists when the optional
//               parity feature is built in, see UART_RX_PARITY_EN)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OS_RATE   = 16;
    localparam int OS_MID    = 7;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // Even parity check: returns 1 when the payload plus its parity bit
    // contain an odd number of ones.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] payload,
                                             input logic                 par_bit);
        return ^{payload, par_bit};
    endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os16_if
// Byte-output side of the UART receiver.
//   data          : received byte, valid while data_valid=1
//   data_valid    : byte available, held until data_valid && data_ready
//   data_ready    : consumer accepts the byte
//   framing_error : one-clk pulse on a bad stop bit
//   overrun       : one-clk pulse when a completed byte had to be dropped
//   parity_error  : one-clk pulse on parity mismatch (0 when parity not built)
// Modports: master = receiver, slave = consumer.
// -----------------------------------------------------------------------------
interface uart_rx_os16_if
    import uart_pkg::*;
;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 framing_error;
    logic                 overrun;
    logic                 parity_error;

    modport master (
        output data,
        output data_valid,
        output framing_error,
        output overrun,
        output parity_error,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  framing_error,
        input  overrun,
        input  parity_error,
        output data_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchronizer for the asynchronous rx line. Every stage resets to
// one so that reset never looks like a start bit.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
// STAGES below 2 is raised to 2; a single flop is not a synchronizer.
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx_os16.sv
// -----------------------------------------------------------------------------
// uart_rx_os16
// 8-bit UART receiver oversampling at 16x baud. enable_16 is a one-clk pulse
// at 16x the bit rate; bits are sampled at their centre (start bit re-checked
// at tick 7, data/parity/stop sampled 16 ticks later each).
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   enable_16 : 16x baud tick
//   rx        : asynchronous serial line, idle high
//   bus       : byte output + handshake + error pulses (uart_rx_os16_if.master)
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the last data bit and the stop bit.
// -----------------------------------------------------------------------------
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_16,
    input  logic            rx,
    uart_rx_os16_if.master  bus
);

    localparam logic [3:0] TICK_MID  = 4'(OS_MID);
    localparam logic [3:0] TICK_LAST = 4'(OS_RATE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    rx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_done;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 par_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        par_err    = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // Falling edge is taken on any clk so the start-bit phase is
                // not quantised to the enable_16 grid.
                if (!rx_s) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                if (enable_16) begin
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            // Line went back high before mid-bit: a glitch.
                            state_d = ST_IDLE;
                        end else begin
                            tick_d  = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (enable_16) begin
                    tick_d = tick_q + 4'd1;   // wraps 15 -> 0
                    if (tick_q == TICK_LAST) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};  // LSB first
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (enable_16) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (enable_16) begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == TICK_LAST) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_mismatch(shift_q, par_q)) begin
                                par_err = 1'b1;
                            end else begin
                                frame_done = 1'b1;
                            end
`else
                            frame_done = 1'b1;
`endif
                        end else begin
                            // Bad stop bit; a held-low line (break) is
                            // absorbed in WAIT_HIGH instead of re-triggering.
                            frame_err = 1'b1;
                            state_d   = ST_WAIT_HIGH;
                        end
                    end
                end
            end

            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output holding register and status pulses
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_q;
    logic                 data_valid_q;
    logic                 framing_error_q;
    logic                 overrun_q;
    logic                 accept_new;

    // A completed byte can be taken when the holder is empty or is being
    // emptied in this very cycle.
    assign accept_new = !data_valid_q || bus.data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            framing_error_q <= frame_err;
            overrun_q       <= frame_done && !accept_new;
            if (frame_done && accept_new) begin
                data_q       <= shift_q;
                data_valid_q <= 1'b1;
            end else if (data_valid_q && bus.data_ready) begin
                data_valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_error_q <= 1'b0;
        end else begin
            parity_error_q <= par_err;
        end
    end

    assign bus.parity_error = parity_error_q;
`else
    assign bus.parity_error = 1'b0;
`endif

    assign bus.data          = data_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.framing_error = framing_error_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: doc/uart_rx_os16.md
UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, rx input synchronizer depth (min 2).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable_16  input  1  one-clk pulse at 16x baud, from the DDS baud clock.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port data  output  8  received byte, valid while data_valid=1.
REQ-007 SHALL have port data_valid  output  1  byte available; held until consumed.
REQ-008 SHALL have port data_ready  input  1  consumer accepts byte when data_valid&&data_ready.
REQ-009 SHALL have port framing_error  output  1  one-clk pulse on bad stop bit.
REQ-010 SHALL have port overrun  output  1  one-clk pulse when a completed byte is dropped.
REQ-011 SHALL have port parity_error  output  1  one-clk pulse on parity mismatch.

Function
REQ-012 SHALL synchronize rx through SYNC_STAGES flops, reset value 1; all sampling uses the synchronized value.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; 4-bit tick counter, 3-bit bit index.
REQ-014 IDLE: synchronized rx=0 on any clk SHALL clear tick counter and enter START, independent of enable_16.
REQ-015 Tick counter SHALL advance only on enable_16 cycles, modulo 16.
REQ-016 START: at tick 7, rx=1 SHALL return to IDLE (glitch, no flag); rx=0 SHALL clear counter, enter DATA.
REQ-017 DATA: at each tick 15, rx SHALL be shifted in LSB-first; after bit 7 enter PARITY (macro on) or STOP.
REQ-018 STOP: at tick 15, rx=1 SHALL complete the frame and enter IDLE; rx=0 SHALL pulse framing_error, discard the byte, enter WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL stay until synchronized rx=1, then enter IDLE (break handling).
REQ-020 On completion, data_valid=0 or data_ready=1 in the same cycle SHALL load data and set data_valid on the next clk.
REQ-021 On completion with data_valid=1 and data_ready=0, the new byte SHALL be dropped, data unchanged, overrun pulsed.
REQ-022 data_valid SHALL clear the cycle after data_valid&&data_ready with no simultaneous completion.
REQ-023 data SHALL be stable while data_valid=1 and data_ready=0.
REQ-024 A frame with framing or parity error SHALL never set data_valid.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, counters 0, data 8'h00, data_valid 0, all error pulses 0, synchronizer ones.
REQ-026 Reset mid-frame SHALL abandon the frame; reception resumes at the next falling edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state SHALL sample one even-parity bit at tick 15; mismatch pulses parity_error at stop completion, byte discarded.
REQ-028 UART_RX_PARITY_EN undefined: PARITY state SHALL be absent, DATA goes to STOP, parity_error tied 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold the state enumeration, OS_RATE=16, OS_MID=7, DATA_BITS=8.
REQ-030 Sub-module uart_rx_sync (parameterized flop chain, reset-to-one) SHALL implement REQ-012.

Verification (enable_16 every 4 clks; bit = 64 clks)
REQ-031 Frame 0xA5, good stop, data_ready=1 -> data=8'hA5, data_valid one cycle, no error pulses.
REQ-032 Low glitch of 20 clks on idle rx -> no data_valid, state back to IDLE, next frame 0x3C received correctly.
REQ-033 Frame 0x55 with stop=0, rx held low 200 clks -> one framing_error pulse, no data_valid, frame 0x81 after rx high received.
REQ-034 data_ready=0, frames 0x11 then 0x22 -> data stays 8'h11, one overrun pulse; data_ready=1 then clears data_valid.
REQ-035 rst_n low during bit 4 of 0xF0, release, send 0x0F -> data=8'h0F only, no errors.
REQ-036 UART_RX_PARITY_EN: 0x07 with parity 1 -> data=8'h07; with parity 0 -> parity_error pulse, no data_valid.
